// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - extension mode constants and pipe state encodings
package ext_pkg;

    localparam int EXTOP_W = 3;

    localparam logic [EXTOP_W-1:0] EXT_ZERO  = 3'b000;
    localparam logic [EXTOP_W-1:0] EXT_SIGN  = 3'b001;
    localparam logic [EXTOP_W-1:0] EXT_LUI   = 3'b010;
    localparam logic [EXTOP_W-1:0] EXT_BR    = 3'b011;
    localparam logic [EXTOP_W-1:0] EXT_JMP   = 3'b100;
    localparam logic [EXTOP_W-1:0] EXT_SHAMT = 3'b101;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/ext_core.sv
// rtl/ext_core.sv - combinational immediate/offset/jump/shamt extender
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int INS_W  = 32,
    parameter int IMM_W  = 16,
    parameter int JMP_W  = 26
) (
    input  logic [EXTOP_W-1:0] i_extop,
    input  logic [INS_W-1:0]   i_ins,
    input  logic [DATA_W-1:0]  i_pc,
    output logic [DATA_W-1:0]  o_value,
    output logic               o_err
);

    logic [IMM_W-1:0]   w_imm;
    logic [DATA_W-1:0]  w_sext;
    logic [2*IMM_W-1:0] w_lui;
    logic               w_unused;

    assign w_imm    = i_ins[IMM_W-1:0];
    assign w_sext   = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    assign w_lui    = {w_imm, {IMM_W{1'b0}}};
    assign w_unused = ^{i_pc[JMP_W+1:0], i_ins[INS_W-1:JMP_W]};

    always_comb begin
        o_value = '0;
        o_err   = 1'b0;
        case (i_extop)
            EXT_ZERO:  o_value = DATA_W'(w_imm);
            EXT_SIGN:  o_value = w_sext;
            EXT_LUI:   o_value = DATA_W'(w_lui);
            EXT_BR:    o_value = w_sext << 2;
            EXT_JMP:   o_value = {i_pc[DATA_W-1:JMP_W+2], i_ins[JMP_W-1:0], 2'b00};
            EXT_SHAMT: o_value = DATA_W'(i_ins[10:6]);
            default:   o_err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - registered extender with valid/ready and 2-entry skid buffer
module ext_pipe
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int INS_W  = 32,
    parameter int IMM_W  = 16,
    parameter int JMP_W  = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_extop,
    input  logic [INS_W-1:0]   in_ins,
    input  logic [DATA_W-1:0]  in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_ext,
    output logic               out_err
);

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_main_ext;
    logic                r_main_err;
    logic [DATA_W-1:0]   r_skid_ext;
    logic                r_skid_err;

    logic [DATA_W-1:0]   w_ext;
    logic                w_err;
    logic                w_accept;
    logic                w_emit;

    ext_core #(
        .DATA_W (DATA_W),
        .INS_W  (INS_W),
        .IMM_W  (IMM_W),
        .JMP_W  (JMP_W)
    ) u_core (
        .i_extop (in_extop),
        .i_ins   (in_ins),
        .i_pc    (in_pc),
        .o_value (w_ext),
        .o_err   (w_err)
    );

    assign w_accept = in_valid & r_in_ready;
    assign w_emit   = r_out_valid & out_ready;

    // Outputs are held in r_main_* even when invalid, so a flush leaves the last value visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_ext  <= '0;
            r_main_err  <= 1'b0;
            r_skid_ext  <= '0;
            r_skid_err  <= 1'b0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main_ext  <= w_ext;
                        r_main_err  <= w_err;
                        r_out_valid <= 1'b1;
                        r_state     <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_emit) begin
                        r_main_ext <= w_ext;
                        r_main_err <= w_err;
                    end else if (w_accept) begin
                        r_skid_ext <= w_ext;
                        r_skid_err <= w_err;
                        r_in_ready <= 1'b0;
                        r_state    <= FULL;
                    end else if (w_emit) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_emit) begin
                        r_main_ext <= r_skid_ext;
                        r_main_err <= r_skid_err;
                        r_in_ready <= 1'b1;
                        r_state    <= ONE;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_ext   = r_main_ext;
    assign out_err   = r_main_err;

    a_skid_implies_main: assert property (@(posedge clk) disable iff (reset)
        (r_state == FULL) |-> r_out_valid);

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - directed self-checking bench for ext_pipe
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_extop = 3'b000;
    logic [31:0] in_ins = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_ext;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    ext_pipe #(.DATA_W(32), .INS_W(32), .IMM_W(16), .JMP_W(26)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_extop  (in_extop),
        .in_ins    (in_ins),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ext   (out_ext),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] ins);
        in_valid = v;
        in_extop = op;
        in_ins   = ins;
    endtask

    logic [2:0]  vec_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0};
    logic [31:0] vec_ins [8] = '{32'h0000_8001, 32'h0000_8001, 32'h0000_8001, 32'h0000_8001,
                                 32'h0BFF_FFFF, 32'h0000_0140, 32'h0000_8001, 32'h0000_8001};
    logic [31:0] vec_exp [8] = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000, 32'hFFFE_0004,
                                 32'hAFFF_FFFC, 32'h0000_0005, 32'h0000_0000, 32'h0000_8001};
    logic        vec_err [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] bp_ins  [4] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};

    initial begin
        logic [31:0] got_q[$];
        int idx;
        int gaps;
        int seen;
        logic acc;
        logic em;

        in_pc = 32'hA000_0004;
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ext", out_ext, 0);
        check("rst_out_err", out_err, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vec_op[i], vec_ins[i]);
            tick();
            check($sformatf("mode%0d_valid", i), out_valid, 1);
            check($sformatf("mode%0d_ext", i), out_ext, vec_exp[i]);
            check($sformatf("mode%0d_err", i), out_err, vec_err[i]);
        end
        drive(1'b0, 3'd0, '0);
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);

        out_ready = 1'b0;
        idx = 0;
        gaps = 0;
        for (int cyc = 1; cyc <= 20 && got_q.size() < 4; cyc++) begin
            if (idx < 4) drive(1'b1, 3'd0, bp_ins[idx]);
            else drive(1'b0, 3'd0, '0);
            acc = in_valid & in_ready;
            em  = out_valid & out_ready;
            if (got_q.size() > 0 && !out_valid) gaps++;
            if (em) got_q.push_back(out_ext);
            tick();
            if (acc) idx++;
            if (cyc == 2) check("bp_in_ready_low", in_ready, 0);
            if (cyc >= 2 && cyc <= 4) begin
                check($sformatf("bp_hold_valid_c%0d", cyc), out_valid, 1);
                check($sformatf("bp_hold_ext_c%0d", cyc), out_ext, 32'h1);
            end
            if (cyc == 4) out_ready = 1'b1;
        end
        check("bp_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check($sformatf("bp_order%0d", i), got_q[i], bp_ins[i]);
        end
        check("bp_gaps", gaps, 0);
        drive(1'b0, 3'd0, '0);
        tick();
        check("bp_empty", out_valid, 0);

        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'h11);
        tick();
        drive(1'b1, 3'd0, 32'h22);
        tick();
        check("fl_full_in_ready", in_ready, 0);
        drive(1'b1, 3'd0, 32'h33);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 3'd0, '0);
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_ext_held", out_ext, 32'h11);
        out_ready = 1'b1;
        seen = 0;
        repeat (4) begin
            tick();
            if (out_valid) seen++;
        end
        check("fl_no_leak", seen, 0);
        drive(1'b1, 3'd0, 32'h44);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 3'd0, '0);
        check("fl_accept_dropped", out_valid, 0);
        drive(1'b1, 3'd0, 32'h55);
        tick();
        check("fl_after_valid", out_valid, 1);
        check("fl_after_ext", out_ext, 32'h55);
        drive(1'b0, 3'd0, '0);
        tick();

        out_ready = 1'b0;
        drive(1'b1, 3'd7, '0);
        tick();
        drive(1'b1, 3'd0, 32'h5);
        tick();
        check("ar_pre_in_ready", in_ready, 0);
        check("ar_pre_err", out_err, 1);
        drive(1'b0, 3'd0, '0);
        #3 reset = 1'b1;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_ext", out_ext, 0);
        check("ar_out_err", out_err, 0);
        check("ar_in_ready", in_ready, 1);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 3'd1, 32'h0000_8001);
        tick();
        check("ar_post_valid", out_valid, 1);
        check("ar_post_ext", out_ext, 32'hFFFF_8001);
        drive(1'b0, 3'd0, '0);
        tick();
        check("ar_post_empty", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
Registered, parametrised immediate extender for the pipelined datapath. It sits between instruction decode and the ID/EX register. It extends the immediate, branch-offset, jump-target and shift-amount fields of an instruction word according to a 3-bit mode. A valid/ready handshake with a 2-entry skid buffer lets hazard stalls and flushes from the pipeline control pass through without dropping or duplicating results.

Parameters:
DATA_W, 32, output width; must satisfy DATA_W >= 2*IMM_W and DATA_W >= JMP_W+2
INS_W, 32, instruction word width
IMM_W, 16, immediate field width, taken from ins[IMM_W-1:0]
JMP_W, 26, jump index width, taken from ins[JMP_W-1:0]

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  discard all buffered results (branch taken / exception)
in_valid  in  1  upstream has an instruction
in_ready  out  1  block can accept this cycle
in_extop  in  3  extension mode
in_ins  in  INS_W  instruction word
in_pc  in  DATA_W  PC+4 of the instruction (jump mode)
out_valid  out  1  out_ext holds a result
out_ready  in  1  downstream accepts
out_ext  out  DATA_W  extended value
out_err  out  1  result came from an illegal extop

Behaviour:
- Reset (async, active-high). Clears both entries: out_valid=0, out_ext=0, out_err=0, in_ready=1. No transfer occurs while reset is high.
- Modes (imm = ins[IMM_W-1:0]):
  - 000: zero-extend imm.
  - 001: sign-extend imm.
  - 010: {imm, IMM_W zeros}, then zero-extended or truncated to DATA_W.
  - 011: sign-extend imm, then shift left 2 (branch offset; top bits discarded).
  - 100: {in_pc[DATA_W-1:JMP_W+2], ins[JMP_W-1:0], 2'b00}.
  - 101: zero-extend ins[10:6] (shamt).
  - 110/111: result 0 with err=1.
  - err=0 for all legal modes.
- Extension logic is combinational on the input side. Results are captured with err into the storage entries.
- Storage: main entry (drives the outputs) and skid entry.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- Latency: an accepted instruction appears on out_* on the next clock edge when the main entry is free or being emitted in the same cycle.
- in_ready is registered and equals "skid entry empty". It must not depend combinationally on out_ready.
- States: EMPTY (none valid), ONE (main valid), FULL (main + skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & emit -> ONE (main reloads); accept & !emit -> FULL (input goes to skid); emit & !accept -> EMPTY.
  - FULL: emit -> ONE (skid moves to main, in_ready=1 next cycle). No accept is possible in FULL.
- Ordering is strict FIFO. No result is duplicated or dropped except by flush.
- flush (synchronous):
  - Next state is EMPTY and in_ready=1.
  - Any same-cycle accept is discarded.
  - A same-cycle emit is still considered completed downstream.
  - out_ext/out_err keep their last value while out_valid=0.
- Stall: while out_valid=1 & out_ready=0, out_ext, out_err and out_valid hold stable.
- Reset asserted mid-transfer: immediate return to the reset values. Any in-flight data is lost.
- An FSM encoding that is EMPTY with the skid entry valid is illegal. The verification assertion is: skid valid implies main valid.

Decomposition:
- Shared package ext_pkg: mode constants EXT_ZERO=3'b000, EXT_SIGN=3'b001, EXT_LUI=3'b010, EXT_BR=3'b011, EXT_JMP=3'b100, EXT_SHAMT=3'b101, and state encodings EMPTY/ONE/FULL. The decoder imports the same constants.
- One sub-module: ext_core, purely combinational (extop, ins, pc -> value, err), parametrised identically. ext_pipe instantiates it once and owns the skid/FSM logic.

Test Plan:
- Reset then single accepts, out_ready=1, ins=32'h0000_8001:
  - extop 000 -> 32'h0000_8001
  - extop 001 -> 32'hFFFF_8001
  - extop 010 -> 32'h8001_0000
  - extop 011 -> 32'hFFFE_0004
  - all with err=0 and 1-cycle latency.
- Jump: extop 100, ins=32'h0BFF_FFFF, pc=32'hA000_0004 -> 32'hAFFF_FFFC. Shamt: extop 101, ins=32'h0000_0140 -> 32'h0000_0005.
- Illegal: extop 111 -> out_ext=0, out_err=1. The following legal op -> out_err=0.
- Back-pressure: stream 4 ops with out_ready=0 -> in_ready falls after 2 accepts, outputs hold stable. Release out_ready -> all 4 results emerge in order with no gaps or duplicates.
- Flush in FULL state with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed and same-cycle inputs never appear.
- Assert reset asynchronously mid-stream (between edges) -> out_valid, out_ext, out_err go to 0 immediately and in_ready=1. After release, the first new op has normal 1-cycle latency.
